mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mips_pkg.sv | 13 +
 rtl/arb_watchdog.sv | 32 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared arbiter definitions: FSM state encoding and default fairness/watchdog limits.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arbState_t;

  localparam int FAIR_LIMIT_DEF = 4;
  localparam int MAX_WAIT_DEF   = 16;

endpackage

// File: rtl/arb_watchdog.sv
// Counts cycles an outstanding memory request goes unacknowledged; flags expiry on the last allowed cycle.
module arb_watchdog
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  input  logic ack,
  output logic expire
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] waitCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (start) begin
      waitCnt <= '0;
    end else if (busy && !ack) begin
      waitCnt <= waitCnt + CW'(1);
    end
  end

  // Fires during the MAX_WAIT-th unacknowledged cycle; an ack in that cycle wins.
  assign expire = busy && !ack && (waitCnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and MEM-stage accesses onto a single-port memory,
// with bounded data priority while a fetch waits and a no-ack watchdog abort.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int FAIR_LIMIT = FAIR_LIMIT_DEF,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  localparam int FW = $clog2(FAIR_LIMIT + 1);

  arbState_t     state;
  logic [FW-1:0] fairCnt;
  logic          dataPend;
  logic          fairHit;
  logic          grantData;
  logic          grantFetch;
  logic          expire;

  assign dataPend   = d_read | d_write;
  assign fairHit    = if_req && (fairCnt == FW'(FAIR_LIMIT));
  assign grantData  = (state == IDLE) && dataPend && !fairHit;
  assign grantFetch = (state == IDLE) && if_req && !grantData;

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = dataPend & ~d_done;

  arb_watchdog #(.MAX_WAIT(MAX_WAIT)) uWatchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (grantData | grantFetch),
    .busy   (mem_req),
    .ack    (mem_ack),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fairCnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grantData) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (if_req && fairCnt != FW'(FAIR_LIMIT)) fairCnt <= fairCnt + FW'(1);
          end else if (grantFetch) begin
            state     <= FETCH;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            fairCnt   <= '0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end else if (expire) begin
            if_rdata <= '0;
            if_done  <= 1'b1;
            bus_err  <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end
        end
        DATA: begin
          // Stores complete without disturbing the last load result.
          if (mem_ack) begin
            if (!mem_we) d_rdata <= mem_rdata;
            d_done  <= 1'b1;
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (expire) begin
            d_rdata <= '0;
            d_done  <= 1'b1;
            bus_err <= 1'b1;
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level arbitration model.
module tb_mem_arbiter;
  import mips_pkg::*;

  localparam int FL = 4;
  localparam int MW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  mem_arbiter #(.FAIR_LIMIT(FL), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          fairModel = 0;
  logic [31:0] expIfRdata = '0;
  logic [31:0] expDRdata = '0;
  int          grantLog[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkStall(input bit ifDoneExp, input bit dDoneExp);
    chk("stall_if", 32'(stall_if), 32'(if_req & ~ifDoneExp));
    chk("stall_mem", 32'(stall_mem), 32'((d_read | d_write) & ~dDoneExp));
  endtask

  // One granted transaction: the model picks the owner from the current requests,
  // the bench acts as memory and acks dly cycles after mem_req first shows.
  task automatic runTxn(input int dly, input bit dropReq, input logic [31:0] rdata);
    bit          toData;
    logic [31:0] eAddr;
    logic [31:0] eWd;
    logic        eWe;
    toData = (d_read | d_write) && !(if_req && fairModel == FL);
    if (toData) begin
      eAddr = d_addr; eWe = d_write; eWd = d_wdata;
      if (if_req && fairModel < FL) fairModel++;
    end else begin
      eAddr = if_addr; eWe = 1'b0; eWd = '0;
      fairModel = 0;
    end
    grantLog.push_back(int'(toData));
    tick();
    chk("mem_req_rise", 32'(mem_req), 1);
    chk("mem_addr", mem_addr, eAddr);
    chk("mem_we", 32'(mem_we), 32'(eWe));
    if (toData) chk("mem_wdata", mem_wdata, eWd);
    chkStall(1'b0, 1'b0);
    if (dropReq) begin
      if (toData) begin d_read = 1'b0; d_write = 1'b0; end
      else if_req = 1'b0;
    end
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("mem_req_hold", 32'(mem_req), 1);
    end
    mem_rdata = rdata;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    if (toData && !eWe) expDRdata = rdata;
    if (!toData) expIfRdata = rdata;
    chk("if_done", 32'(if_done), 32'(!toData));
    chk("d_done", 32'(d_done), 32'(toData));
    chk("if_rdata", if_rdata, expIfRdata);
    chk("d_rdata", d_rdata, expDRdata);
    chk("mem_req_fall", 32'(mem_req), 0);
    chk("bus_err_clear", 32'(bus_err), 0);
    chkStall(!toData, toData);
  endtask

  int expSeq[6] = '{1, 1, 1, 1, 0, 1};
  int ifLeft;
  int dLeft;
  int dataDone;
  int kind;

  initial begin
    // Reset state
    tick();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_done", 32'(d_done), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    rst_n = 1'b1;
    tick();

    // Basic fetch, ack two cycles after mem_req
    if_req = 1'b1; if_addr = 32'h40;
    runTxn(2, 1'b0, 32'hDEADBEEF);
    chk("fetch_word", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    tick();

    // Simultaneous write and fetch: data first, then fetch
    d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'h12345678;
    if_req = 1'b1; if_addr = 32'h80;
    runTxn(1, 1'b0, $urandom);
    chk("first_owner_data", grantLog[grantLog.size()-1], 1);
    d_write = 1'b0;
    runTxn(0, 1'b0, $urandom);
    chk("second_owner_fetch", grantLog[grantLog.size()-1], 0);
    if_req = 1'b0;
    tick();

    // Fairness: five loads against a waiting fetch
    grantLog.delete();
    d_read = 1'b1; d_addr = 32'h200; if_req = 1'b1; if_addr = 32'h300;
    dataDone = 0;
    while (dataDone < 5 && grantLog.size() < 8) begin
      runTxn(int'($urandom_range(0, 2)), 1'b0, $urandom);
      if (grantLog[grantLog.size()-1] == 0) if_req = 1'b0;
      else dataDone++;
    end
    d_read = 1'b0;
    chk("fair_len", grantLog.size(), 6);
    for (int i = 0; i < 6 && i < grantLog.size(); i++) chk("fair_order", grantLog[i], expSeq[i]);
    tick();

    // Ack on the last watchdog cycle completes normally
    d_read = 1'b1; d_addr = 32'h500;
    runTxn(MW - 1, 1'b0, 32'hA5A5_0001);
    d_read = 1'b0;
    tick();

    // Ack while idle is ignored
    mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
    chk("idle_ack_if_done", 32'(if_done), 0);
    chk("idle_ack_d_done", 32'(d_done), 0);
    chk("idle_ack_mem_req", 32'(mem_req), 0);
    chk("idle_ack_d_rdata", d_rdata, expDRdata);

    // Watchdog abort on an unacknowledged load
    d_read = 1'b1; d_addr = 32'h600;
    tick();
    chk("wd_req_rise", 32'(mem_req), 1);
    for (int i = 0; i < MW - 1; i++) begin
      tick();
      chk("wd_req_hold", 32'(mem_req), 1);
    end
    tick();
    chk("wd_req_drop", 32'(mem_req), 0);
    chk("wd_bus_err", 32'(bus_err), 1);
    chk("wd_d_done", 32'(d_done), 1);
    chk("wd_d_rdata", d_rdata, 0);
    expDRdata = '0;
    d_read = 1'b0;
    tick();
    chk("wd_bus_err_pulse", 32'(bus_err), 0);
    chk("wd_d_done_pulse", 32'(d_done), 0);

    // Request dropped after grant still completes
    if_req = 1'b1; if_addr = 32'h700;
    runTxn(1, 1'b1, $urandom);
    tick();

    // Reset in the second FETCH cycle
    if_req = 1'b1; if_addr = 32'h800;
    tick();
    chk("rst_mid_req", 32'(mem_req), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(mem_req), 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_rdata", if_rdata, 0);
    fairModel = 0; expIfRdata = '0; expDRdata = '0;
    tick();
    chk("rst_no_done", 32'(if_done), 0);
    rst_n = 1'b1;
    runTxn(1, 1'b0, $urandom);
    chk("post_rst_fetch", grantLog[grantLog.size()-1], 0);

    // Randomized traffic
    ifLeft = 20; dLeft = 20;
    if_req = 1'b1; if_addr = $urandom;
    d_read = 1'b1; d_write = 1'b0; d_addr = $urandom; d_wdata = $urandom;
    while (if_req || d_read || d_write) begin
      runTxn(int'($urandom_range(0, 4)), 1'b0, $urandom);
      if (grantLog[grantLog.size()-1] == 0) begin
        if (ifLeft > 0) begin ifLeft--; if_req = 1'b1; if_addr = $urandom; end
        else if_req = 1'b0;
      end else begin
        if (dLeft > 0) begin
          dLeft--;
          kind = int'($urandom_range(0, 2));
          d_read = (kind != 1); d_write = (kind != 0);
          d_addr = $urandom; d_wdata = $urandom;
        end else begin
          d_read = 1'b0; d_write = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
